// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode encodings, FSM states, flag bit positions.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ILL = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int unsigned FLAG_ZERO     = 0;
    localparam int unsigned FLAG_NEGATIVE = 1;
    localparam int unsigned FLAG_OVERFLOW = 2;
    localparam int unsigned FLAG_CARRY    = 3;

    function automatic logic [3:0] pack_flags(input logic carry, input logic overflow,
                                              input logic negative, input logic zero);
        logic [3:0] r;
        r = '0;
        r[FLAG_CARRY]    = carry;
        r[FLAG_OVERFLOW] = overflow;
        r[FLAG_NEGATIVE] = negative;
        r[FLAG_ZERO]     = zero;
        return r;
    endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle; done holds until the next start.
module seq_alu_mul #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;

    // The start edge already folds in b[0], so the final bit lands WIDTH-1 cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (start) begin
            acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier <= {1'b0, b[WIDTH-1:1]};
            count  <= CW'(1);
        end else if (count != '0 && count != LAST) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
        end
    end

    assign done    = (count == LAST);
    assign product = acc;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes; single-cycle ops plus a multi-cycle unsigned MUL.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic [3:0]       flags,
    output logic             err
);

    opcode_t            op;
    state_t             state;
    state_t             state_next;
    logic               transfer;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     shl_ext;
    logic [WIDTH-1:0]   alu_y;
    logic               alu_c;
    logic               alu_v;
    logic               alu_err;

    assign op        = opcode_t'(f);
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign transfer  = in_ready && in_valid;
    assign mul_start = transfer && (op == OP_MUL);

    seq_alu_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start),
        .a      (a),
        .b      (b),
        .done   (mul_done),
        .product(mul_product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_valid) state_next = (op == OP_MUL) ? S_BUSY : S_DONE;
            S_BUSY:  if (mul_done) state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Single-cycle datapath; bit WIDTH of each extended result is the carry/borrow/last-shifted-out bit.
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        shl_ext = {1'b0, a} << b[SHW-1:0];
        alu_y   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (op)
            OP_ADD: begin
                alu_y = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_y = diff[WIDTH-1:0];
                alu_c = diff[WIDTH];
                alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_y = a & b;
            OP_OR:  alu_y = a | b;
            OP_NOT: alu_y = ~a;
            OP_SHL: begin
                alu_y = shl_ext[WIDTH-1:0];
                alu_c = shl_ext[WIDTH];
            end
            OP_MUL: alu_y = '0;
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y     <= '0;
            y_hi  <= '0;
            flags <= '0;
            err   <= 1'b0;
        end else if (transfer && (op != OP_MUL)) begin
            y     <= alu_y;
            y_hi  <= '0;
            flags <= pack_flags(alu_c, alu_v, alu_y[WIDTH-1], alu_y == '0);
            err   <= alu_err;
        end else if ((state == S_BUSY) && mul_done) begin
            y     <= mul_product[WIDTH-1:0];
            y_hi  <= mul_product[2*WIDTH-1:WIDTH];
            flags <= pack_flags(|mul_product[2*WIDTH-1:WIDTH], 1'b0,
                                mul_product[WIDTH-1], mul_product[WIDTH-1:0] == '0);
            err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): vector table, random ops vs. a reference model, corner sequences.
module tb_seq_alu;

    typedef struct {
        logic [2:0] f;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic [7:0] y_hi;
        logic [3:0] flags;
        logic       err;
        int         lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] f = '0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] y;
    logic [7:0] y_hi;
    logic [3:0] flags;
    logic       err;

    vec_t sb[$];
    int   checks = 0;
    int   failures = 0;

    seq_alu #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .f        (f),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .y_hi     (y_hi),
        .flags    (flags),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [7:0] x, input logic [7:0] z,
                                input logic [7:0] ry, input logic [7:0] rh, input logic [3:0] fl,
                                input logic e, input int lat);
        vec_t r;
        r.f = op; r.a = x; r.b = z; r.y = ry; r.y_hi = rh; r.flags = fl; r.err = e; r.lat = lat;
        return r;
    endfunction

    // Reference model written with integer arithmetic rather than bit tricks.
    function automatic vec_t model(input logic [2:0] op, input logic [7:0] x, input logic [7:0] z);
        vec_t        r;
        int          u;
        int          s;
        int unsigned sh;
        logic [15:0] p;
        logic        c;
        logic        v;
        r.f = op; r.a = x; r.b = z; r.y = '0; r.y_hi = '0; r.err = 1'b0; r.lat = 1;
        c = 1'b0; v = 1'b0;
        case (op)
            3'b001: begin
                u = int'(x) + int'(z);
                s = int'($signed(x)) + int'($signed(z));
                r.y = u[7:0]; c = (u > 255); v = (s > 127) || (s < -128);
            end
            3'b010: begin
                u = int'(x) - int'(z);
                s = int'($signed(x)) - int'($signed(z));
                r.y = u[7:0]; c = (x < z); v = (s > 127) || (s < -128);
            end
            3'b011: r.y = x & z;
            3'b100: r.y = x | z;
            3'b101: r.y = ~x;
            3'b110: begin
                sh = int'(z) % 8;
                u = int'(x) << sh;
                r.y = u[7:0]; c = (sh != 0) && u[8];
            end
            3'b111: begin
                p = 16'(x) * 16'(z);
                r.y = p[7:0]; r.y_hi = p[15:8]; c = |p[15:8]; r.lat = 9;
            end
            default: r.err = 1'b1;
        endcase
        r.flags = {c, v, r.y[7], (r.y == 8'h00)};
        return r;
    endfunction

    task automatic compare_out(input string tag);
        vec_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_y"}, y, e.y);
        check({tag, "_y_hi"}, y_hi, e.y_hi);
        check({tag, "_flags"}, flags, e.flags);
        check({tag, "_err"}, err, e.err);
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int k;
        bit busy_ok;
        k = 0;
        while (!in_ready && k < 30) begin
            @(posedge clk); #1; k++;
        end
        check({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1; a = v.a; b = v.b; f = v.f;
        @(posedge clk);
        sb.push_back(v);
        #1;
        in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); f = 3'($urandom);
        k = 1;
        busy_ok = 1'b1;
        while (!out_valid && k < 40) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1; k++;
        end
        check({tag, "_latency"}, k, v.lat);
        check({tag, "_busy_ready"}, busy_ok, 1);
        compare_out(tag);
        @(posedge clk); #1;
        check({tag, "_released"}, out_valid, 0);
    endtask

    initial begin
        vec_t tbl[15];
        vec_t e;
        bit   seen;

        tbl[0]  = mk(3'b001, 8'hF0, 8'h20, 8'h10, 8'h00, 4'b1000, 1'b0, 1);
        tbl[1]  = mk(3'b001, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b0110, 1'b0, 1);
        tbl[2]  = mk(3'b010, 8'h05, 8'h07, 8'hFE, 8'h00, 4'b1010, 1'b0, 1);
        tbl[3]  = mk(3'b111, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b1000, 1'b0, 9);
        tbl[4]  = mk(3'b110, 8'h81, 8'h01, 8'h02, 8'h00, 4'b1000, 1'b0, 1);
        tbl[5]  = mk(3'b000, 8'h55, 8'hAA, 8'h00, 8'h00, 4'b0001, 1'b1, 1);
        tbl[6]  = mk(3'b011, 8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000, 1'b0, 1);
        tbl[7]  = mk(3'b100, 8'h80, 8'h01, 8'h81, 8'h00, 4'b0010, 1'b0, 1);
        tbl[8]  = mk(3'b101, 8'hFF, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b0, 1);
        tbl[9]  = mk(3'b110, 8'h81, 8'h08, 8'h81, 8'h00, 4'b0010, 1'b0, 1);
        tbl[10] = mk(3'b110, 8'h81, 8'h07, 8'h80, 8'h00, 4'b0010, 1'b0, 1);
        tbl[11] = mk(3'b111, 8'h00, 8'h05, 8'h00, 8'h00, 4'b0001, 1'b0, 9);
        tbl[12] = mk(3'b111, 8'h10, 8'h10, 8'h00, 8'h01, 4'b1001, 1'b0, 9);
        tbl[13] = mk(3'b010, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b0100, 1'b0, 1);
        tbl[14] = mk(3'b001, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b1001, 1'b0, 1);

        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_y", y, 0);
        check("reset_y_hi", y_hi, 0);
        check("reset_flags", flags, 0);
        check("reset_err", err, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_op(tbl[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 24; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            run_op(model(op, 8'($urandom), 8'($urandom)), $sformatf("rnd%0d", i));
        end

        // Backpressure: result must hold in DONE while a new request waits.
        out_ready = 1'b0;
        in_valid = 1'b1; a = 8'h12; b = 8'h34; f = 3'b001;
        @(posedge clk);
        sb.push_back(model(3'b001, 8'h12, 8'h34));
        #1;
        a = 8'h0F; b = 8'hF0; f = 3'b100;
        check("bp_valid", out_valid, 1);
        e = sb[0];
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_y_c%0d", i), y, e.y);
            check($sformatf("bp_flags_c%0d", i), flags, e.flags);
            check($sformatf("bp_ready_c%0d", i), in_ready, 0);
            check($sformatf("bp_ovalid_c%0d", i), out_valid, 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        compare_out("bp_first");
        @(posedge clk); #1;
        check("bp_after_hs_valid", out_valid, 0);
        check("bp_after_hs_ready", in_ready, 1);
        @(posedge clk);
        sb.push_back(model(3'b100, 8'h0F, 8'hF0));
        #1;
        in_valid = 1'b0;
        check("bp_second_valid", out_valid, 1);
        compare_out("bp_second");
        @(posedge clk); #1;

        // Reset three cycles into a MUL discards it.
        in_valid = 1'b1; a = 8'hFF; b = 8'hFF; f = 3'b111;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_in_ready", in_ready, 1);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_y", y, 0);
        check("mrst_y_hi", y_hi, 0);
        check("mrst_flags", flags, 0);
        check("mrst_err", err, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("mrst_no_valid", seen, 0);
        run_op(model(3'b111, 8'h0D, 8'h0B), "post_rst_mul");
        run_op(model(3'b001, 8'h40, 8'h40), "post_rst_add");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
